// File: rtl/dmem_axil_master_pkg.sv
// Shared constants and types for the data-memory AXI4-Lite master.
// funct3 codes, AXI response codes and FSM state encoding.
package dmem_axil_master_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 == FUNCT3_LB) || (f3 == FUNCT3_LH) ||
           (f3 == FUNCT3_LW) || (f3 == FUNCT3_LBU) ||
           (f3 == FUNCT3_LHU);
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3);
    return (f3 == FUNCT3_SB) || (f3 == FUNCT3_SH) ||
           (f3 == FUNCT3_SW);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational; funct3[2] selects zero-extension on loads.
module dmem_lane_align
  import dmem_axil_master_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_aligned,
  output logic [31:0] rdata_extended,
  output logic        misaligned
);

  logic [31:0] shifted;
  logic        sx;

  always_comb begin
    shifted        = rdata >> {off, 3'b000};
    sx             = ~funct3[2];
    wstrb          = 4'b0000;
    wdata_aligned  = '0;
    rdata_extended = '0;
    misaligned     = 1'b0;
    unique case (funct3[1:0])
      2'b00: begin
        wstrb          = 4'b0001 << off;
        wdata_aligned  = {4{wdata[7:0]}};
        rdata_extended = {{24{sx & shifted[7]}},
                          shifted[7:0]};
      end
      2'b01: begin
        wstrb          = 4'b0011 << off;
        wdata_aligned  = {2{wdata[15:0]}};
        rdata_extended = {{16{sx & shifted[15]}},
                          shifted[15:0]};
        misaligned     = off[0];
      end
      2'b10: begin
        wstrb          = 4'b1111;
        wdata_aligned  = wdata;
        rdata_extended = rdata;
        misaligned     = (off != 2'b00);
      end
      default: begin
        wstrb = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_axil_master.sv
// Data-memory access unit: one AXI4-Lite read or write per
// memory-stage request, with a single-cycle completion pulse.
module dmem_axil_master
  import dmem_axil_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic              C_CMEM,
  input  logic              C_DOLOAD,
  input  logic              C_DOSTORE,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [2:0]        MEM_FUNCT3,
  input  logic [31:0]       MEM_WDATA,
  output logic              C_MEM_DONE,
  output logic              MEM_ERR,
  output logic [31:0]       LOAD_DATA,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [2:0]        M_AXI_ARPROT,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic [2:0]        M_AXI_AWPROT,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [DATA_W-1:0] M_AXI_WDATA,
  output logic [3:0]        M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [31:0]       wdata_q;
  logic              aw_done, aw_done_n;
  logic              w_done, w_done_n;
  logic [31:0]       ld_q, ld_n;
  logic              err_q, err_n;

  logic [3:0]        strb;
  logic [31:0]       wd_al;
  logic [31:0]       rd_ext;
  logic              misal;
  logic              aw_hs, w_hs;

  dmem_lane_align u_align (
    .funct3         (f3_q),
    .off            (addr_q[1:0]),
    .wdata          (wdata_q),
    .rdata          (M_AXI_RDATA),
    .wstrb          (strb),
    .wdata_aligned  (wd_al),
    .rdata_extended (rd_ext),
    .misaligned     (misal)
  );

  assign M_AXI_ARADDR  = {addr_q[ADDR_W-1:2], 2'b00};
  assign M_AXI_AWADDR  = {addr_q[ADDR_W-1:2], 2'b00};
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = wd_al;
  assign M_AXI_WSTRB   = strb;
  assign M_AXI_ARVALID = (state == ST_RD_ADDR);
  assign M_AXI_RREADY  = (state == ST_RD_DATA);
  assign M_AXI_AWVALID = (state == ST_WR_REQ) && !aw_done;
  assign M_AXI_WVALID  = (state == ST_WR_REQ) && !w_done;
  assign M_AXI_BREADY  = (state == ST_WR_RESP);
  assign C_MEM_DONE    = (state == ST_DONE);
  assign MEM_ERR       = err_q;
  assign LOAD_DATA     = ld_q;

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      ld_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
      ld_q    <= ld_n;
      err_q   <= err_n;
      if (state == ST_IDLE && C_CMEM) begin
        addr_q  <= MEM_ADDR;
        f3_q    <= MEM_FUNCT3;
        wdata_q <= MEM_WDATA;
      end
    end
  end

  always_comb begin
    state_n   = state;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    ld_n      = ld_q;
    err_n     = err_q;
    unique case (state)
      ST_IDLE: begin
        // Illegal requests complete locally without touching the bus.
        if ((C_DOLOAD && C_DOSTORE) ||
            (C_DOLOAD && (!load_f3_ok(f3_q) || misal)) ||
            (C_DOSTORE && (!store_f3_ok(f3_q) || misal))) begin
          state_n = ST_DONE;
          err_n   = 1'b1;
          ld_n    = '0;
        end else if (C_DOLOAD) begin
          state_n = ST_RD_ADDR;
        end else if (C_DOSTORE) begin
          state_n   = ST_WR_REQ;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
        end
      end
      ST_RD_ADDR: begin
        if (M_AXI_ARREADY) state_n = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (M_AXI_RVALID) begin
          state_n = ST_DONE;
          err_n   = (M_AXI_RRESP != AXI_RESP_OKAY);
          ld_n    = (M_AXI_RRESP != AXI_RESP_OKAY) ? '0 : rd_ext;
        end
      end
      ST_WR_REQ: begin
        aw_done_n = aw_done | aw_hs;
        w_done_n  = w_done | w_hs;
        if ((aw_done | aw_hs) && (w_done | w_hs)) begin
          state_n   = ST_WR_RESP;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
        end
      end
      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
          state_n = ST_DONE;
          err_n   = (M_AXI_BRESP != AXI_RESP_OKAY);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_axil_master.sv
// Directed bench for dmem_axil_master: stimulus pushes expected
// completions into a queue, a monitor checks each done pulse.
module tb_dmem_axil_master;

  logic        CLK;
  logic        NRST;
  logic        C_CMEM, C_DOLOAD, C_DOSTORE;
  logic [31:0] MEM_ADDR;
  logic [2:0]  MEM_FUNCT3;
  logic [31:0] MEM_WDATA;
  logic        C_MEM_DONE, MEM_ERR;
  logic [31:0] LOAD_DATA;
  logic [31:0] M_AXI_ARADDR;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID, M_AXI_RREADY;
  logic [31:0] M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY;

  int total = 0;
  int bad = 0;
  // {check_data, err, data}
  logic [33:0] sb[$];
  logic [33:0] e;

  dmem_axil_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .NRST(NRST),
    .C_CMEM(C_CMEM), .C_DOLOAD(C_DOLOAD), .C_DOSTORE(C_DOSTORE),
    .MEM_ADDR(MEM_ADDR), .MEM_FUNCT3(MEM_FUNCT3),
    .MEM_WDATA(MEM_WDATA),
    .C_MEM_DONE(C_MEM_DONE), .MEM_ERR(MEM_ERR),
    .LOAD_DATA(LOAD_DATA),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act,
                      input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (NRST && C_MEM_DONE) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no done");
      end else begin
        e = sb.pop_front();
        chkb("mon_mem_err", MEM_ERR, e[32]);
        if (e[33]) chk("mon_load_data", LOAD_DATA, e[31:0]);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, input logic ld,
                       input logic st, input logic [33:0] exp);
    @(negedge CLK);
    C_CMEM = 1'b1;
    MEM_ADDR = a;
    MEM_FUNCT3 = f3;
    MEM_WDATA = wd;
    @(negedge CLK);
    C_CMEM = 1'b0;
    MEM_ADDR = 32'hFFFF_FFFF;
    C_DOLOAD = ld;
    C_DOSTORE = st;
    sb.push_back(exp);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] rd, input logic [1:0] rr,
                         input int stall, input logic [31:0] expd,
                         input logic experr);
    logic [31:0] aa;
    aa = {a[31:2], 2'b00};
    issue(a, f3, 32'h0, 1'b1, 1'b0, {1'b1, experr, expd});
    for (int i = 0; i <= stall; i++) begin
      @(negedge CLK);
      chkb("arvalid", M_AXI_ARVALID, 1'b1);
      chk("araddr", M_AXI_ARADDR, aa);
      chk("arprot", {29'b0, M_AXI_ARPROT}, 32'h0);
      M_AXI_ARREADY = (i == stall);
    end
    @(negedge CLK);
    M_AXI_ARREADY = 1'b0;
    chkb("arvalid_drop", M_AXI_ARVALID, 1'b0);
    chkb("rready", M_AXI_RREADY, 1'b1);
    M_AXI_RVALID = 1'b1;
    M_AXI_RDATA = rd;
    M_AXI_RRESP = rr;
    @(negedge CLK);
    M_AXI_RVALID = 1'b0;
    M_AXI_RDATA = 32'h0;
    M_AXI_RRESP = 2'b00;
    chkb("load_done", C_MEM_DONE, 1'b1);
    C_DOLOAD = 1'b0;
    @(negedge CLK);
    chkb("done_one_cycle", C_MEM_DONE, 1'b0);
    chk("load_hold", LOAD_DATA, expd);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, input int aws,
                          input int ws, input int bdly,
                          input logic [1:0] br, input logic [3:0] xs,
                          input logic [31:0] xw);
    logic ag, wg;
    int ac, wc;
    ag = 1'b0; wg = 1'b0; ac = 0; wc = 0;
    issue(a, f3, wd, 1'b0, 1'b1, {1'b0, br != 2'b00, 32'h0});
    for (int i = 0; i < 30 && !(ag && wg); i++) begin
      @(negedge CLK);
      M_AXI_AWREADY = 1'b0;
      M_AXI_WREADY = 1'b0;
      chkb("bready_early", M_AXI_BREADY, 1'b0);
      chkb("awvalid", M_AXI_AWVALID, !ag);
      chkb("wvalid", M_AXI_WVALID, !wg);
      if (!ag) begin
        chk("awaddr", M_AXI_AWADDR, {a[31:2], 2'b00});
        if (ac == aws) begin
          M_AXI_AWREADY = 1'b1;
          ag = 1'b1;
        end else ac++;
      end
      if (!wg) begin
        chk("wstrb", {28'b0, M_AXI_WSTRB}, {28'b0, xs});
        chk("wdata", M_AXI_WDATA, xw);
        if (wc == ws) begin
          M_AXI_WREADY = 1'b1;
          wg = 1'b1;
        end else wc++;
      end
    end
    if (!(ag && wg)) begin
      total++;
      bad++;
      $display("FAIL store_timeout: got no handshake want aw+w");
    end
    @(negedge CLK);
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY = 1'b0;
    for (int i = 0; i < bdly; i++) begin
      chkb("bready", M_AXI_BREADY, 1'b1);
      chkb("done_before_b", C_MEM_DONE, 1'b0);
      @(negedge CLK);
    end
    chkb("bready", M_AXI_BREADY, 1'b1);
    chkb("awvalid_after", M_AXI_AWVALID, 1'b0);
    chkb("wvalid_after", M_AXI_WVALID, 1'b0);
    M_AXI_BVALID = 1'b1;
    M_AXI_BRESP = br;
    @(negedge CLK);
    M_AXI_BVALID = 1'b0;
    M_AXI_BRESP = 2'b00;
    chkb("store_done", C_MEM_DONE, 1'b1);
    C_DOSTORE = 1'b0;
    @(negedge CLK);
    chkb("done_one_cycle", C_MEM_DONE, 1'b0);
  endtask

  task automatic do_err(input logic [31:0] a, input logic [2:0] f3,
                        input logic ld, input logic st);
    issue(a, f3, 32'h5555_5555, ld, st, {1'b1, 1'b1, 32'h0});
    @(negedge CLK);
    chkb("err_done", C_MEM_DONE, 1'b1);
    chkb("err_no_ar", M_AXI_ARVALID, 1'b0);
    chkb("err_no_aw", M_AXI_AWVALID, 1'b0);
    chkb("err_no_w", M_AXI_WVALID, 1'b0);
    C_DOLOAD = 1'b0;
    C_DOSTORE = 1'b0;
    @(negedge CLK);
    chkb("done_one_cycle", C_MEM_DONE, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    NRST = 1'b0;
    C_CMEM = 1'b0; C_DOLOAD = 1'b0; C_DOSTORE = 1'b0;
    MEM_ADDR = '0; MEM_FUNCT3 = '0; MEM_WDATA = '0;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
    M_AXI_RDATA = '0; M_AXI_RRESP = '0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
    M_AXI_BVALID = 1'b0; M_AXI_BRESP = '0;
    repeat (2) @(negedge CLK);
    chkb("rst_arvalid", M_AXI_ARVALID, 1'b0);
    chkb("rst_rready", M_AXI_RREADY, 1'b0);
    chkb("rst_awvalid", M_AXI_AWVALID, 1'b0);
    chkb("rst_wvalid", M_AXI_WVALID, 1'b0);
    chkb("rst_bready", M_AXI_BREADY, 1'b0);
    chkb("rst_done", C_MEM_DONE, 1'b0);
    chkb("rst_err", MEM_ERR, 1'b0);
    chk("rst_load_data", LOAD_DATA, 32'h0);
    NRST = 1'b1;

    do_load(32'h0000_1003, 3'b000, 32'h80FF_0000, 2'b00, 0,
            32'hFFFF_FF80, 1'b0);
    do_load(32'h0000_2002, 3'b101, 32'hBEEF_1234, 2'b00, 0,
            32'h0000_BEEF, 1'b0);
    do_load(32'h0000_2002, 3'b001, 32'hBEEF_1234, 2'b00, 0,
            32'hFFFF_BEEF, 1'b0);
    do_load(32'h0000_6001, 3'b100, 32'h1122_3344, 2'b00, 1,
            32'h0000_0033, 1'b0);
    do_store(32'h0000_3002, 3'b001, 32'h0000_ABCD, 3, 0, 2, 2'b00,
             4'b1100, 32'hABCD_ABCD);
    do_store(32'h0000_5001, 3'b000, 32'h1234_5678, 0, 2, 0, 2'b11,
             4'b0010, 32'h7878_7878);
    do_store(32'h0000_A004, 3'b010, 32'h0102_0304, 0, 0, 0, 2'b00,
             4'b1111, 32'h0102_0304);
    do_err(32'h0000_4001, 3'b010, 1'b0, 1'b1);
    do_load(32'h4000_0008, 3'b010, 32'h1234_5678, 2'b10, 5,
            32'h0000_0000, 1'b1);
    do_err(32'h0000_7001, 3'b001, 1'b1, 1'b0);
    do_err(32'h0000_7000, 3'b011, 1'b1, 1'b0);
    do_err(32'h0000_7000, 3'b011, 1'b0, 1'b1);
    do_err(32'h0000_7000, 3'b010, 1'b1, 1'b1);
    do_load(32'h0000_7000, 3'b010, 32'hDEAD_BEEF, 2'b00, 0,
            32'hDEAD_BEEF, 1'b0);

    // Abort a load in RD_DATA with an asynchronous reset.
    issue(32'h0000_8000, 3'b010, 32'h0, 1'b1, 1'b0, 34'h0);
    @(negedge CLK);
    chkb("pre_rst_arvalid", M_AXI_ARVALID, 1'b1);
    M_AXI_ARREADY = 1'b1;
    @(negedge CLK);
    M_AXI_ARREADY = 1'b0;
    chkb("pre_rst_rready", M_AXI_RREADY, 1'b1);
    #2 NRST = 1'b0;
    #1;
    chkb("arst_arvalid", M_AXI_ARVALID, 1'b0);
    chkb("arst_rready", M_AXI_RREADY, 1'b0);
    chkb("arst_done", C_MEM_DONE, 1'b0);
    chk("arst_load_data", LOAD_DATA, 32'h0);
    void'(sb.pop_back());
    C_DOLOAD = 1'b0;
    repeat (2) @(negedge CLK);
    NRST = 1'b1;
    repeat (2) @(negedge CLK);
    chkb("post_rst_idle", C_MEM_DONE, 1'b0);
    do_load(32'h0000_9000, 3'b010, 32'hCAFE_F00D, 2'b00, 0,
            32'hCAFE_F00D, 1'b0);

    repeat (3) @(negedge CLK);
    chk("sb_empty", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_axil_master.md
Name: dmem_axil_master

Overview:
- Data-memory access unit for the multicycle RV32I core. Sits directly downstream of the pipeline control FSM's memory stage.
- Latches the load/store request during EXEC (C_CMEM). Runs one AXI4-Lite read or write transaction while C_DOLOAD/C_DOSTORE is held in S_MEM.
- Returns C_MEM_DONE plus byte-lane-aligned, sign- or zero-extended load data for writeback.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width (fixed at 32 for RV32I; other values unsupported).

Ports:
- CLK  in  1  core clock
- NRST  in  1  asynchronous active-low reset
- C_CMEM  in  1  latch request fields (EXEC-stage pulse)
- C_DOLOAD  in  1  perform load; held until C_MEM_DONE
- C_DOSTORE  in  1  perform store; held until C_MEM_DONE
- MEM_ADDR  in  ADDR_W  byte address (rs1+imm)
- MEM_FUNCT3  in  3  instruction funct3
- MEM_WDATA  in  32  rs2 value
- C_MEM_DONE  out  1  one-cycle completion pulse
- MEM_ERR  out  1  valid with C_MEM_DONE: misaligned, illegal funct3, or bus error
- LOAD_DATA  out  32  extended load result
- M_AXI_ARADDR/ARPROT/ARVALID  out  ADDR_W/3/1; M_AXI_ARREADY  in  1
- M_AXI_RDATA/RRESP/RVALID  in  32/2/1; M_AXI_RREADY  out  1
- M_AXI_AWADDR/AWPROT/AWVALID  out  ADDR_W/3/1; M_AXI_AWREADY  in  1
- M_AXI_WDATA/WSTRB/WVALID  out  32/4/1; M_AXI_WREADY  in  1
- M_AXI_BRESP/BVALID  in  2/1; M_AXI_BREADY  out  1

Behaviour:
- Reset (async, NRST=0):
  - State IDLE.
  - All VALID/READY outputs, C_MEM_DONE, MEM_ERR and LOAD_DATA = 0; latched request cleared.
  - Reset mid-transaction abandons the transaction immediately; no done pulse follows.
- Request latch:
  - On C_CMEM in IDLE, register addr, funct3 and wdata.
  - C_CMEM outside IDLE is ignored.
- Address and lane mapping:
  - AXI address = latched addr with bits[1:0] forced to 0. PROT = 3'b000.
  - off = addr[1:0].
  - Store byte (000): WSTRB = 4'b0001<<off, WDATA = {4{wdata[7:0]}}.
  - Store half (001): WSTRB = 4'b0011<<off, WDATA = {2{wdata[15:0]}}.
  - Store word (010): WSTRB = 4'hF, WDATA = wdata.
  - LB/LBU (000/100): byte RDATA[8*off+:8], sign-/zero-extended.
  - LH/LHU (001/101): half RDATA[8*off+:16], sign-/zero-extended.
  - LW (010): RDATA unchanged.
- Errors detected in IDLE (no bus transaction issued):
  - Half access with off odd.
  - Word access with off≠0.
  - Funct3 011/110/111 for loads; funct3 ≥011 for stores.
  - C_DOLOAD and C_DOSTORE both high.
  - Response: go to DONE with MEM_ERR=1, LOAD_DATA=0.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
  - IDLE: on C_DOLOAD → RD_ADDR (ARVALID=1 next cycle). On C_DOSTORE → WR_REQ (AWVALID=WVALID=1 next cycle). On error → DONE.
  - RD_ADDR: hold ARVALID/ARADDR stable until ARREADY, then → RD_DATA with RREADY=1.
  - RD_DATA: on RVALID, register extended LOAD_DATA, set MEM_ERR=(RRESP≠OKAY), → DONE. On error, LOAD_DATA=0.
  - WR_REQ: AW and W complete independently. Track with aw_done/w_done flags; each VALID drops after its own handshake. When both are done (same or different cycles) → WR_RESP with BREADY=1.
  - WR_RESP: on BVALID, MEM_ERR=(BRESP≠OKAY), → DONE.
  - DONE: C_MEM_DONE=1 for exactly this cycle, then → IDLE. The controller leaves S_MEM on this pulse, so C_DOLOAD/C_DOSTORE are low when IDLE is re-entered and no duplicate transaction is issued.
- Output stability:
  - VALIDs never drop before their handshake.
  - LOAD_DATA and MEM_ERR hold until the next transaction completes.
- Minimum latency, zero-wait slave:
  - Load: DOLOAD seen at cycle 0 → ARVALID at cycle 1 → RVALID at cycle 2 → C_MEM_DONE at cycle 3.
  - Store: same, 3 cycles.
- Back-pressure: arbitrary READY/VALID stalls are supported with no timeout.

Decomposition:
- define.vh additions: `FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW`, `AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR`, FSM state encodings.
- One combinational sub-module, dmem_lane_align, implements the lane mapping. Inputs: funct3, off, wdata, rdata. Outputs: wstrb, wdata_aligned, rdata_extended, misaligned.

Test Plan:
- Load LB at addr 0x1003, RDATA=0x80FF_0000 → ARADDR=0x1000; LOAD_DATA=0xFFFF_FF80, MEM_ERR=0, C_MEM_DONE 3 cycles after DOLOAD.
- Load LHU at addr 0x2002, RDATA=0xBEEF_1234 → LOAD_DATA=0x0000_BEEF. Same access with LH → 0xFFFF_BEEF.
- Store SH at addr 0x3002, wdata=0x0000_ABCD → AWADDR=0x3000, WSTRB=4'b1100, WDATA=0xABCD_ABCD. Run with AWREADY delayed 3 cycles and WREADY immediate; done only after BVALID.
- Store SW at addr 0x4001 → no AW/W activity, C_MEM_DONE with MEM_ERR=1 one cycle after DOSTORE.
- LW with ARREADY stalled 5 cycles and RRESP=SLVERR → ARVALID/ARADDR stable throughout; MEM_ERR=1, LOAD_DATA=0.
- Assert NRST=0 while in RD_DATA → ARVALID/RREADY/C_MEM_DONE drop to 0 asynchronously. After release, the next load completes normally.
